// File: rtl/tube_bus_arbiter_pkg.sv
// Shared encodings for the tube bus arbiter: FSM states, requester ids, default tube base.
// Pure definitions; no timing or flow-control behaviour of its own.
package tube_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DBG = 1'b1;

    localparam logic [31:0] TUBE_BASE_DEFAULT = 32'h0000_7F50;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, grants whichever requester was not granted last.
// Purely combinational, zero latency; holds no state and applies no backpressure.
module rr_arb2
    import tube_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_id_o,
    output logic       gnt_valid_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = ID_CPU;
        if (&req_i) begin
            gnt_id_o = ~last_grant_i;
        end else if (req_i[ID_DBG]) begin
            gnt_id_o = ID_DBG;
        end
    end

endmodule

// File: rtl/tube_bus_arbiter.sv
// Shares the tube sign/num register pair between the CPU bridge and the debug loader.
// Grant at IDLE edge, one device cycle, ack one cycle later; requests wait until the FSM is back in IDLE.
module tube_bus_arbiter
    import tube_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TUBE_BASE_DEFAULT,
    parameter int unsigned ADDR_SPAN = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [3:0]  dbg_byteen,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [31:0] dev_addr,
    output logic        dev_we,
    output logic [3:0]  dev_byteen,
    output logic [31:0] dev_wd,
    input  logic [31:0] dev_rd,
    output logic        busy,
    output logic        addr_err
);

    state_e      state_q, state_d;
    logic        last_grant_q;
    logic        gnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;
    logic [31:0] rdata_q;
    logic        gnt_id;
    logic        gnt_valid;
    logic        in_range;

    rr_arb2 u_rr_arb2 (
        .req_i        ({dbg_req, cpu_req}),
        .last_grant_i (last_grant_q),
        .gnt_id_o     (gnt_id),
        .gnt_valid_o  (gnt_valid)
    );

    // Upper bound done in 33 bits so a base near the top of the map cannot wrap.
    assign in_range = (addr_q >= BASE_ADDR) &&
                      ({1'b0, addr_q} < ({1'b0, BASE_ADDR} + 33'(ADDR_SPAN)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (gnt_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_DBG;
            gnt_q        <= ID_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wd_q         <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && gnt_valid) begin
                gnt_q        <= gnt_id;
                last_grant_q <= gnt_id;
                if (gnt_id == ID_DBG) begin
                    we_q   <= dbg_we;
                    addr_q <= dbg_addr;
                    be_q   <= dbg_byteen;
                    wd_q   <= dbg_wdata;
                end else begin
                    we_q   <= cpu_we;
                    addr_q <= cpu_addr;
                    be_q   <= cpu_byteen;
                    wd_q   <= cpu_wdata;
                end
            end
            if (state_q == ST_ACCESS) begin
                rdata_q <= in_range ? dev_rd : '0;
            end
        end
    end

    // Device bus follows the latches directly, so it only moves on a new grant.
    assign dev_addr   = addr_q;
    assign dev_byteen = be_q;
    assign dev_wd     = wd_q;
    assign dev_we     = (state_q == ST_ACCESS) && we_q && in_range;

    assign busy      = (state_q != ST_IDLE);
    assign cpu_ack   = (state_q == ST_RESP) && (gnt_q == ID_CPU);
    assign dbg_ack   = (state_q == ST_RESP) && (gnt_q == ID_DBG);
    assign cpu_rdata = cpu_ack ? rdata_q : '0;
    assign dbg_rdata = dbg_ack ? rdata_q : '0;
    assign addr_err  = (state_q == ST_RESP) && !in_range;

endmodule

// File: tb/tb_tube_bus_arbiter.sv
// Scoreboard bench for tube_bus_arbiter: directed transactions push expected device/ack events,
// a negedge monitor pops and compares each event the DUT presents.
`timescale 1ns/1ps
module tb_tube_bus_arbiter;

    localparam logic [31:0] BASE     = 32'h0000_7F50;
    localparam logic [31:0] SIGN_VAL = 32'hA5A5_0001;
    localparam logic [31:0] NUM_VAL  = 32'h0000_BEEF;
    localparam int EV_WE   = 0;
    localparam int EV_CACK = 1;
    localparam int EV_DACK = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] dat;
        logic [3:0]  be;
        logic        err;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  mon_k;
    ev_t mon_e;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  cpu_byteen, dbg_byteen;
    logic        cpu_ack, dbg_ack, dev_we, busy, addr_err;
    logic [31:0] cpu_rdata, dbg_rdata, dev_addr, dev_wd, dev_rd;
    logic [3:0]  dev_byteen;

    tube_bus_arbiter #(.BASE_ADDR(BASE), .ADDR_SPAN(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_byteen (cpu_byteen),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_byteen (dbg_byteen),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .dev_addr   (dev_addr),
        .dev_we     (dev_we),
        .dev_byteen (dev_byteen),
        .dev_wd     (dev_wd),
        .dev_rd     (dev_rd),
        .busy       (busy),
        .addr_err   (addr_err)
    );

    assign dev_rd = dev_addr[2] ? NUM_VAL : SIGN_VAL;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (!cpu_ack) chk("cpu_rdata_zero", cpu_rdata, 32'h0);
            if (!dbg_ack) chk("dbg_rdata_zero", dbg_rdata, 32'h0);
            if (!cpu_ack && !dbg_ack) chk("addr_err_quiet", 32'(addr_err), 32'h0);
            if (dev_we || cpu_ack || dbg_ack) begin
                mon_k = dev_we ? EV_WE : (cpu_ack ? EV_CACK : EV_DACK);
                chk("one_event_per_cycle", 32'(dev_we) + 32'(cpu_ack) + 32'(dbg_ack), 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: kind=%0d at cycle %0d, expected none", mon_k, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", mon_k, mon_e.kind);
                    chk("event_cycle", cyc, mon_e.cyc);
                    if (mon_k == EV_WE) begin
                        chk("dev_addr", dev_addr, mon_e.addr);
                        chk("dev_wd", dev_wd, mon_e.dat);
                        chk("dev_byteen", 32'(dev_byteen), 32'(mon_e.be));
                    end else begin
                        chk("ack_rdata", (mon_k == EV_CACK) ? cpu_rdata : dbg_rdata, mon_e.dat);
                        chk("addr_err", 32'(addr_err), 32'(mon_e.err));
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Expected events for one grant sampled at edge e.
    task automatic push_txn(input int who, input int e, input logic we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        ev_t  ev;
        logic inr;
        inr = (a >= BASE) && (a < BASE + 32'd8);
        ev.addr = a;
        ev.be   = be;
        if (we && inr) begin
            ev.kind = EV_WE; ev.cyc = e; ev.dat = wd; ev.err = 1'b0;
            exp_q.push_back(ev);
        end
        ev.kind = who;
        ev.cyc  = e + 1;
        ev.dat  = inr ? (a[2] ? NUM_VAL : SIGN_VAL) : 32'h0;
        ev.err  = !inr;
        exp_q.push_back(ev);
    endtask

    task automatic drive(input int who, input logic req, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (who == EV_CACK) begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_byteen = be; cpu_wdata = wd;
        end else begin
            dbg_req = req; dbg_we = we; dbg_addr = a; dbg_byteen = be; dbg_wdata = wd;
        end
    endtask

    task automatic single(input int who, input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        int e;
        e = cyc + 1;
        drive(who, 1'b1, we, a, be, wd);
        push_txn(who, e, we, a, be, wd);
        wait_cyc(e + 1);
        drive(who, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wait_cyc(e + 2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset_n = 1'b1;
        drive(EV_CACK, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(EV_DACK, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("rst_dbg_ack", 32'(dbg_ack), 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_dev_we", 32'(dev_we), 32'h0);
        chk("rst_dev_addr", dev_addr, 32'h0);
        chk("rst_dev_wd", dev_wd, 32'h0);
        chk("rst_dev_byteen", 32'(dev_byteen), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // CPU write to num register, busy over the access window
        e = cyc + 1;
        drive(EV_CACK, 1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'h1234_5678);
        push_txn(EV_CACK, e, 1'b1, BASE + 32'd4, 4'hF, 32'h1234_5678);
        chk("busy_before", 32'(busy), 32'h0);
        wait_cyc(e);
        chk("busy_access", 32'(busy), 32'h1);
        wait_cyc(e + 1);
        chk("busy_resp", 32'(busy), 32'h1);
        drive(EV_CACK, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wait_cyc(e + 2);
        chk("busy_after", 32'(busy), 32'h0);

        // Tie right after reset: CPU first, then strict alternation over 6 grants
        do_reset();
        e = cyc + 1;
        drive(EV_CACK, 1'b1, 1'b1, BASE, 4'h3, 32'hC0C0_0001);
        drive(EV_DACK, 1'b1, 1'b1, BASE + 32'd4, 4'hC, 32'hD0D0_0002);
        for (int g = 0; g < 6; g++) begin
            if (g % 2 == 0) push_txn(EV_CACK, e + 3 * g, 1'b1, BASE, 4'h3, 32'hC0C0_0001);
            else            push_txn(EV_DACK, e + 3 * g, 1'b1, BASE + 32'd4, 4'hC, 32'hD0D0_0002);
        end
        wait_cyc(e + 16);
        drive(EV_CACK, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(EV_DACK, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wait_cyc(e + 17);

        // Single transactions: reads, out-of-range, zero byte-enable, range edges
        single(EV_CACK, 1'b0, BASE,           4'hF, 32'h0);
        single(EV_DACK, 1'b1, BASE + 32'd8,   4'hF, 32'h9999_0000);
        single(EV_DACK, 1'b1, BASE + 32'd4,   4'h0, 32'hDEAD_BEEF);
        single(EV_CACK, 1'b0, BASE - 32'd4,   4'hF, 32'h0);
        single(EV_DACK, 1'b0, BASE + 32'd7,   4'hF, 32'h0);

        // Reset during ACCESS: dev_we drops at once, no ack, then a clean retry
        e = cyc + 1;
        drive(EV_CACK, 1'b1, 1'b1, BASE, 4'hF, 32'h1111_2222);
        push_txn(EV_WE, e, 1'b1, BASE, 4'hF, 32'h1111_2222);
        void'(exp_q.pop_back());
        wait_cyc(e);
        chk("mid_access_dev_we", 32'(dev_we), 32'h1);
        #1 reset_n = 1'b0;
        drive(EV_CACK, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("reset_drops_dev_we", 32'(dev_we), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_no_ack", 32'(cpu_ack), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'(busy), 32'h0);
        single(EV_CACK, 1'b1, BASE, 4'hF, 32'h3333_4444);

        // CPU holds req through its ack: second access follows three cycles later
        e = cyc + 1;
        drive(EV_CACK, 1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'h5555_6666);
        push_txn(EV_CACK, e,     1'b1, BASE + 32'd4, 4'hF, 32'h5555_6666);
        push_txn(EV_CACK, e + 3, 1'b1, BASE + 32'd4, 4'hF, 32'h5555_6666);
        wait_cyc(e + 4);
        drive(EV_CACK, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wait_cyc(e + 8);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
